// File: rtl/mealy_seq_detector_param_if.sv
// ---------------------------------------------------------------------------
// mealy_seq_detector_param_if
// Bundle of the serial-input strobe/data/clear signals and the detector
// status outputs for mealy_seq_detector_param.
//   step      : bit strobe (rising edge consumes din)
//   din       : serial data bit
//   clr       : synchronous clear of match_cnt / cnt_sat
//   match     : Mealy match (combinational)
//   match_q   : match delayed one clock
//   match_cnt : saturating match counter
//   cnt_sat   : counter at all-ones
//   state_o   : current matched-prefix length
// master drives the inputs (board/test side), slave is the detector.
// ---------------------------------------------------------------------------
interface mealy_seq_detector_param_if #(
    parameter int CNT_W = 8,
    parameter int ST_W  = 2
);
    logic             step;
    logic             din;
    logic             clr;
    logic             match;
    logic             match_q;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic [ST_W-1:0]  state_o;

    modport master (
        output step, din, clr,
        input  match, match_q, match_cnt, cnt_sat, state_o
    );

    modport slave (
        input  step, din, clr,
        output match, match_q, match_cnt, cnt_sat, state_o
    );
endinterface

// File: rtl/mealy_seq_detector_param.sv
// ---------------------------------------------------------------------------
// mealy_seq_detector_param
// Detects a compile-time bit PATTERN (PAT_LEN bits, MSB received first) in a
// serial stream advanced one bit per rising edge of step. The state is the
// KMP automaton state (length of the longest pattern prefix that is a suffix
// of the bits seen); its transition table is derived from PATTERN at
// elaboration time.
// Ports:
//   CLOCK_125_p : system clock, rising edge
//   reset       : synchronous, active-high
//   bus (slave) : step/din/clr in; match/match_q/match_cnt/cnt_sat/state_o out
// ---------------------------------------------------------------------------
module mealy_seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    parameter int                 ST_W    = $clog2(PAT_LEN)
) (
    input  logic                        CLOCK_125_p,
    input  logic                        reset,
    mealy_seq_detector_param_if.slave   bus
);

    // Table spans every encodable state so that indexing by state_reg is
    // always in range; unreachable states fall back to 0.
    localparam int               N_ST    = 1 << ST_W;
    localparam logic [ST_W-1:0]  LAST_ST = ST_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
            $error("mealy_seq_detector_param: PAT_LEN must be in 2..16");
        end
        if (ST_W < $clog2(PAT_LEN)) begin : g_bad_stw
            $error("mealy_seq_detector_param: ST_W too narrow for PAT_LEN");
        end
    endgenerate

    // i-th bit in arrival order (0 = first received = MSB of PATTERN).
    function automatic logic pat_bit(input int i);
        if (i < 0 || i >= PAT_LEN)
            return 1'b0;
        return PATTERN[PAT_LEN-1-i];
    endfunction

    // Next state from prefix length s after receiving bit b: longest proper
    // pattern prefix (length <= PAT_LEN-1) that is a suffix of prefix(s)+b.
    // Capping at PAT_LEN-1 makes a completed match fall back to fail(PAT_LEN).
    function automatic int kmp_next(input int s, input int b);
        int   best;
        int   idx;
        logic ok;
        logic tbit;
        best = 0;
        if (s >= PAT_LEN)
            return 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    idx  = s + 1 - k + j;
                    tbit = (idx == s) ? b[0] : pat_bit(idx);
                    if (tbit != pat_bit(j))
                        ok = 1'b0;
                end
                if (ok)
                    best = k;
            end
        end
        return best;
    endfunction

    logic [ST_W-1:0] nxt_tbl [N_ST][2];
    logic            exp_tbl [N_ST];

    generate
        for (genvar gi = 0; gi < N_ST; gi++) begin : g_st
            assign exp_tbl[gi] = pat_bit(gi);
            for (genvar gb = 0; gb < 2; gb++) begin : g_bit
                localparam int NXT = kmp_next(gi, gb);
                assign nxt_tbl[gi][gb] = ST_W'(NXT);
            end
        end
    endgenerate

    logic [ST_W-1:0]  state_reg, state_next;
    logic             step_q_reg;
    logic             match_q_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sat_reg;
    logic             step_pulse;
    logic             hit;
    logic             match_comb;

    assign step_pulse = bus.step & ~step_q_reg;
    assign hit        = (bus.din == exp_tbl[state_reg]);

    // State register; step_q resets high so a step held through reset
    // does not look like a fresh rising edge.
    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            state_reg   <= '0;
            step_q_reg  <= 1'b1;
            match_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            step_q_reg  <= bus.step;
            match_q_reg <= match_comb;
        end
    end

    // Next-state logic. The KMP table already yields s+1 on a hit below the
    // last position and fail(PAT_LEN) on a full match.
    always_comb begin
        state_next = state_reg;
        if (step_pulse) begin
            if (!OVERLAP && hit && state_reg == LAST_ST)
                state_next = '0;
            else
                state_next = nxt_tbl[state_reg][bus.din];
        end
    end

    // Mealy output: zero-latency match on the pulse carrying the last bit.
    always_comb begin
        match_comb = 1'b0;
        if (!reset && step_pulse && hit && state_reg == LAST_ST)
            match_comb = 1'b1;
    end

    // Saturating counter; clr wins over a coincident match.
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.clr)
            cnt_next = '0;
        else if (match_comb && cnt_reg != CNT_MAX)
            cnt_next = cnt_reg + 1'b1;
    end

    always_ff @(posedge CLOCK_125_p) begin
        if (reset) begin
            cnt_reg <= '0;
            sat_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            sat_reg <= (cnt_next == CNT_MAX);
        end
    end

    assign bus.match     = match_comb;
    assign bus.match_q   = match_q_reg;
    assign bus.match_cnt = cnt_reg;
    assign bus.cnt_sat   = sat_reg;
    assign bus.state_o   = state_reg;

endmodule

// File: tb/tb_mealy_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_mealy_seq_detector_param
// Three detectors (pattern 1011) share one stimulus stream:
//   ov  : OVERLAP=1, CNT_W=8
//   nov : OVERLAP=0, CNT_W=8
//   sat : OVERLAP=1, CNT_W=2
// Directed steps with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_mealy_seq_detector_param;

    logic clk;
    logic reset;
    logic step;
    logic din;
    logic clr;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mealy_seq_detector_param_if #(.CNT_W(8), .ST_W(2)) if_ov  ();
    mealy_seq_detector_param_if #(.CNT_W(8), .ST_W(2)) if_nov ();
    mealy_seq_detector_param_if #(.CNT_W(2), .ST_W(2)) if_sat ();

    assign if_ov.step  = step;
    assign if_ov.din   = din;
    assign if_ov.clr   = clr;
    assign if_nov.step = step;
    assign if_nov.din  = din;
    assign if_nov.clr  = clr;
    assign if_sat.step = step;
    assign if_sat.din  = din;
    assign if_sat.clr  = clr;

    mealy_seq_detector_param #(
        .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8), .ST_W(2)
    ) dut_ov (
        .CLOCK_125_p(clk),
        .reset      (reset),
        .bus        (if_ov.slave)
    );

    mealy_seq_detector_param #(
        .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8), .ST_W(2)
    ) dut_nov (
        .CLOCK_125_p(clk),
        .reset      (reset),
        .bus        (if_nov.slave)
    );

    mealy_seq_detector_param #(
        .PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2), .ST_W(2)
    ) dut_sat (
        .CLOCK_125_p(clk),
        .reset      (reset),
        .bus        (if_sat.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        step  = 1'b0;
        clr   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One step pulse carrying bit b. Checks the Mealy output in the pulse
    // cycle, then state/match_q after the edge, and that match lasted one clock.
    task automatic bit_in(input logic b, input logic m_ov, input int st_ov,
                          input logic use_nov, input logic m_nov, input int st_nov);
        @(negedge clk);
        din  = b;
        step = 1'b1;
        #1;
        $display("bit din=%0d match_ov=%0d match_nov=%0d", b, if_ov.match, if_nov.match);
        chk("match_ov", 32'(if_ov.match), 32'(m_ov));
        chk("match_sat", 32'(if_sat.match), 32'(m_ov));
        if (use_nov)
            chk("match_nov", 32'(if_nov.match), 32'(m_nov));
        @(negedge clk);
        #1;
        chk("state_ov", 32'(if_ov.state_o), 32'(st_ov));
        chk("match_q_ov", 32'(if_ov.match_q), 32'(m_ov));
        chk("match_ov_1clk", 32'(if_ov.match), 32'd0);
        if (use_nov) begin
            chk("state_nov", 32'(if_nov.state_o), 32'(st_nov));
            chk("match_q_nov", 32'(if_nov.match_q), 32'(m_nov));
        end
        step = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        step  = 1'b1;
        din   = 1'b0;
        clr   = 1'b0;

        // Reset held 3 cycles with step high.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", 32'(if_ov.state_o), 32'd0);
        chk("rst_cnt", 32'(if_ov.match_cnt), 32'd0);
        chk("rst_match_q", 32'(if_ov.match_q), 32'd0);
        chk("rst_match", 32'(if_ov.match), 32'd0);
        chk("rst_sat", 32'(if_ov.cnt_sat), 32'd0);
        din   = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("post-reset step held: state_ov=%0d match=%0d", if_ov.state_o, if_ov.match);
        chk("hold_state", 32'(if_ov.state_o), 32'd0);
        chk("hold_match", 32'(if_ov.match), 32'd0);
        step = 1'b0;
        @(negedge clk);

        // Stream 1,0,1,1,0,1,1.
        bit_in(1'b1, 1'b0, 1, 1'b1, 1'b0, 1);
        bit_in(1'b0, 1'b0, 2, 1'b1, 1'b0, 2);
        bit_in(1'b1, 1'b0, 3, 1'b1, 1'b0, 3);
        bit_in(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        bit_in(1'b0, 1'b0, 2, 1'b1, 1'b0, 0);
        bit_in(1'b1, 1'b0, 3, 1'b1, 1'b0, 1);
        bit_in(1'b1, 1'b1, 1, 1'b1, 1'b0, 1);
        chk("cnt_ov_stream", 32'(if_ov.match_cnt), 32'd2);
        chk("cnt_nov_stream", 32'(if_nov.match_cnt), 32'd1);

        // KMP fallback: 1,0,1,0,1,1.
        do_reset();
        bit_in(1'b1, 1'b0, 1, 1'b1, 1'b0, 1);
        bit_in(1'b0, 1'b0, 2, 1'b1, 1'b0, 2);
        bit_in(1'b1, 1'b0, 3, 1'b1, 1'b0, 3);
        bit_in(1'b0, 1'b0, 2, 1'b1, 1'b0, 2);
        bit_in(1'b1, 1'b0, 3, 1'b1, 1'b0, 3);
        bit_in(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        chk("cnt_ov_kmp", 32'(if_ov.match_cnt), 32'd1);

        // Saturation on the 2-bit counter.
        do_reset();
        bit_in(1'b1, 1'b0, 1, 1'b0, 1'b0, 0);
        bit_in(1'b0, 1'b0, 2, 1'b0, 1'b0, 0);
        bit_in(1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
        bit_in(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
        chk("sat_cnt_m1", 32'(if_sat.match_cnt), 32'd1);
        chk("sat_flag_m1", 32'(if_sat.cnt_sat), 32'd0);
        for (int m = 2; m <= 5; m++) begin
            bit_in(1'b0, 1'b0, 2, 1'b0, 1'b0, 0);
            bit_in(1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
            bit_in(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
            $display("match %0d: sat cnt=%0d cnt_sat=%0d", m, if_sat.match_cnt, if_sat.cnt_sat);
            chk("sat_cnt", 32'(if_sat.match_cnt), 32'((m > 3) ? 3 : m));
            chk("sat_flag", 32'(if_sat.cnt_sat), 32'((m >= 3) ? 1 : 0));
        end
        chk("ov_cnt_5", 32'(if_ov.match_cnt), 32'd5);
        bit_in(1'b0, 1'b0, 2, 1'b0, 1'b0, 0);
        bit_in(1'b1, 1'b0, 3, 1'b0, 1'b0, 0);
        clr = 1'b1;
        bit_in(1'b1, 1'b1, 1, 1'b0, 1'b0, 0);
        clr = 1'b0;
        chk("clr_cnt_sat", 32'(if_sat.match_cnt), 32'd0);
        chk("clr_flag_sat", 32'(if_sat.cnt_sat), 32'd0);
        chk("clr_cnt_ov", 32'(if_ov.match_cnt), 32'd0);

        // Step held high for 10 cycles with din toggling: one bit consumed.
        do_reset();
        @(negedge clk);
        step = 1'b1;
        din  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            din = ~din;
        end
        @(negedge clk);
        #1;
        $display("step held 10 cycles: state_ov=%0d", if_ov.state_o);
        chk("held_state", 32'(if_ov.state_o), 32'd1);
        chk("held_match", 32'(if_ov.match), 32'd0);
        step = 1'b0;
        bit_in(1'b0, 1'b0, 2, 1'b1, 1'b0, 2);
        bit_in(1'b1, 1'b0, 3, 1'b1, 1'b0, 3);

        // Reset mid-pattern.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        $display("mid-pattern reset: state_ov=%0d", if_ov.state_o);
        chk("midrst_state_ov", 32'(if_ov.state_o), 32'd0);
        chk("midrst_state_nov", 32'(if_nov.state_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        bit_in(1'b1, 1'b0, 1, 1'b1, 1'b0, 1);
        bit_in(1'b0, 1'b0, 2, 1'b1, 1'b0, 2);
        bit_in(1'b1, 1'b0, 3, 1'b1, 1'b0, 3);
        bit_in(1'b1, 1'b1, 1, 1'b1, 1'b1, 0);
        chk("final_cnt_ov", 32'(if_ov.match_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
